robs_divider: RTL and testbench
===============================

// Module: robs_divider
// PURPOSE
//  Signed two's-complement divider; inverse of the robsmult multiplier.
//  Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor.
//  Returns a WIDTH-bit quotient and remainder. Quotient truncates toward zero;
//  remainder takes the dividend's sign.
//  FSM control plus a shift/subtract datapath.
//  Sits beside robsmult; a product can be fed back in to recover the operands.
// PARAMETERS
//  WIDTH  8  operand width; dividend is 2*WIDTH bits, quotient and remainder are WIDTH bits
// PORTS
//  clk        in   1          rising-edge clock; the only clock
//  reset      in   1          synchronous, active-high reset
//  start      in   1          request; sampled only in IDLE or DONE
//  dividend   in   2*WIDTH    signed; captured on the accepting edge
//  divisor    in   WIDTH      signed; captured on the accepting edge
//  quotient   out  WIDTH      signed result; valid while done=1
//  remainder  out  WIDTH      signed result; valid while done=1
//  done       out  1          level; result ready, held until the next accepted start or reset
//  busy       out  1          high in INIT/ITER/FIX
//  ovf        out  1          quotient not representable in WIDTH signed bits (includes divide-by-zero)
//  divzero    out  1          divisor was zero
// BEHAVIOUR
//  Reset: state=IDLE; quotient, remainder, done, busy, ovf, divzero all 0; counter 0.
//   Reset overrides everything, including an operation in flight; no partial result survives.
//  States and transitions:
//   IDLE -start-> INIT -> ITER (2*WIDTH cycles) -> FIX -> DONE -start-> INIT.
//   DONE with start=0 stays in DONE; IDLE with start=0 stays in IDLE.
//  Input rules:
//   start is ignored while busy; operand changes after capture are ignored.
//   Accepting start in DONE drops done and all flags on the same edge.
//  INIT:
//   magnitudes |dividend| (2*WIDTH-bit unsigned) and |divisor| (WIDTH-bit unsigned);
//   record sign_q = sign(dividend) ^ sign(divisor), sign_r = sign(dividend).
//   |most-negative| is exact in unsigned form.
//  ITER (unsigned restoring division, one quotient bit per cycle, MSB first):
//   partial remainder PR is WIDTH+1 bits;
//   PR = {PR, dividend MSB} - |divisor|; if the result is >= 0, keep it and set the quotient bit to 1;
//   otherwise restore PR and set the bit to 0.
//   The counter runs 2*WIDTH-1 down to 0.
//  FIX:
//   negate the magnitudes per sign_q/sign_r and register the outputs;
//   done=1 on the FIX->DONE edge.
//  Latency: start edge = 0; done is high after edge 2*WIDTH+2 (18 for WIDTH=8), fixed.
//   Divide-by-zero uses the same latency.
//  Overflow (ovf=1, remainder=0):
//   Condition: magnitude quotient > 2^(WIDTH-1)-1 with sign_q=0, or > 2^(WIDTH-1) with sign_q=1.
//   Saturate quotient: 0x7F..F when sign_q=0, 0x80..0 when sign_q=1.
//  Divide-by-zero (divisor=0): divzero=1, ovf=1, remainder=0;
//   quotient = 0x7F..F if dividend >= 0, else 0x80..0.
//  Outputs are registered and change only on the FIX edge or on reset/accepted start.
// STRUCTURE
//  Package robs_pkg:
//   typedef enum logic [2:0] div_state_t {IDLE, INIT, ITER, FIX, DONE};
//   localparam control-bit indices for datapath strobes (load, shift, sub, fix).
//  Top level: FSM plus iteration counter.
//  Sub-module robs_div_datapath #(WIDTH): magnitude regs, PR/quotient shift regs,
//   subtractor, sign fix, saturation; returns a PR-negative status to the control.
// TESTING (WIDTH=8, results checked when done=1 and at the exact latency)
//  100/7 -> quotient=14 (0x0E), remainder=2; ovf=0, divzero=0; done exactly 18 cycles after start
//  -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100/-7 -> quotient=0xF2, remainder=0x02
//  16256 (0x3F80) / -127 -> quotient=0x80 (-128), remainder=0, ovf=0 (boundary fits);
//   16256/127 -> quotient=0x7F, ovf=1, remainder=0
//  1000/0 -> divzero=1, ovf=1, quotient=0x7F, remainder=0;
//   -1000/0 -> quotient=0x80; same 18-cycle latency
//  start pulsed and operands changed mid-ITER -> ignored; result matches the captured operands
//  reset asserted mid-ITER -> next edge: IDLE with all outputs 0;
//   a fresh start then completes 42/-5 -> quotient=0xF8 (-8), remainder=2

Source files
------------

// File: rtl/robs_pkg.sv
// Shared types and control-strobe layout for the robs_divider block.
package robs_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Bit positions of the control-to-datapath strobe vector.
  localparam int CTL_LOAD  = 0;  // capture raw operands, clear result flags
  localparam int CTL_INIT  = 1;  // form magnitudes and record signs
  localparam int CTL_SHIFT = 2;  // one restoring-division step
  localparam int CTL_SUB   = 3;  // commit the trial subtraction this step
  localparam int CTL_FIX   = 4;  // apply signs / saturation, register outputs
  localparam int CTL_W     = 5;

endpackage

// File: rtl/robs_div_datapath.sv
// Shift/subtract datapath: magnitude registers, partial remainder, quotient
// shift register, sign fix-up and overflow saturation.
module robs_div_datapath
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CTL_W-1:0]   ctl,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               pr_neg,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               divzero
);

  localparam logic [2*WIDTH-1:0] Q_POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] Q_NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  // dq holds the raw dividend after load, its magnitude after init, and
  // gradually becomes the magnitude quotient as bits shift in at the LSB.
  logic [2*WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     pr_q, pr_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               ovf_q, ovf_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH+1:0]   wide;
  logic [WIDTH+2:0]   diff;
  logic               keep;
  logic               ovf_cond;
  logic [WIDTH-1:0]   q_lo, r_lo;

  // Trial subtraction of the shifted partial remainder against |divisor|.
  always_comb begin
    wide   = {pr_q, dq_q[2*WIDTH-1]};
    diff   = {1'b0, wide} - {3'b000, dvs_q};
    pr_neg = diff[WIDTH+2];
    keep   = ctl[CTL_SUB];
    q_lo   = dq_q[WIDTH-1:0];
    r_lo   = pr_q[WIDTH-1:0];
    ovf_cond = dz_q
             | (!sign_q_q && (dq_q > Q_POS_MAX))
             | ( sign_q_q && (dq_q > Q_NEG_MAX));
  end

  // Next-state for all datapath registers, one strobe at a time.
  always_comb begin
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    divzero_d   = divzero_q;

    if (ctl[CTL_LOAD]) begin
      dq_d      = dividend;
      dvs_d     = divisor;
      ovf_d     = 1'b0;
      divzero_d = 1'b0;
    end

    if (ctl[CTL_INIT]) begin
      // Two's-complement negation of the most-negative value yields the
      // exact unsigned magnitude, so no special case is needed.
      dq_d     = dq_q[2*WIDTH-1] ? -dq_q : dq_q;
      dvs_d    = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
      pr_d     = '0;
      sign_q_d = dq_q[2*WIDTH-1] ^ dvs_q[WIDTH-1];
      sign_r_d = dq_q[2*WIDTH-1];
      dz_d     = (dvs_q == '0);
    end

    if (ctl[CTL_SHIFT]) begin
      pr_d = keep ? diff[WIDTH:0] : wide[WIDTH:0];
      dq_d = {dq_q[2*WIDTH-2:0], keep};
    end

    if (ctl[CTL_FIX]) begin
      // With a zero divisor sign_q equals the dividend sign, so the common
      // saturation path yields the required divide-by-zero quotient.
      ovf_d     = ovf_cond;
      divzero_d = dz_q;
      if (ovf_cond) begin
        quotient_d  = sign_q_q ? SAT_NEG : SAT_POS;
        remainder_d = '0;
      end else begin
        quotient_d  = sign_q_q ? -q_lo : q_lo;
        remainder_d = sign_r_q ? -r_lo : r_lo;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dq_q        <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      divzero_q   <= 1'b0;
    end else begin
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      divzero_q   <= divzero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign divzero   = divzero_q;

endmodule

// File: rtl/robs_divider.sv
// Signed 2W/W divider: sequencing FSM and iteration down-counter wrapped
// around the shift/subtract datapath.
//
//   state | meaning
//   IDLE  | waiting for start, no result held
//   INIT  | operands captured; forming magnitudes and signs
//   ITER  | one restoring step per cycle, counter 2W-1 down to 0
//   FIX   | sign fix-up / saturation into output registers
//   DONE  | result valid; start launches a new division
module robs_divider
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               done,
  output logic               busy,
  output logic               ovf,
  output logic               divzero
);

  localparam int              CNT_W   = $clog2(2*WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2*WIDTH-1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTL_W-1:0] ctl;
  logic             pr_neg;

  // Next-state, counter and datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ctl[CTL_LOAD] = 1'b1;
          state_d       = INIT;
        end
      end
      INIT: begin
        ctl[CTL_INIT] = 1'b1;
        cnt_d         = CNT_MAX;
        state_d       = ITER;
      end
      ITER: begin
        ctl[CTL_SHIFT] = 1'b1;
        ctl[CTL_SUB]   = ~pr_neg;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        ctl[CTL_FIX] = 1'b1;
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == INIT) || (state_q == ITER) || (state_q == FIX);
  assign done = (state_q == DONE);

  robs_div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .ctl       (ctl),
    .dividend  (dividend),
    .divisor   (divisor),
    .pr_neg    (pr_neg),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .divzero   (divzero)
  );

endmodule

// File: tb/tb_robs_divider.sv
// Directed bench for robs_divider (WIDTH=8): table of divisions plus
// hand-written sequences for mid-operation start and reset.
module tb_robs_divider;

  localparam int W   = 8;
  localparam int LAT = 2*W + 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient, remainder;
  logic           done, busy, ovf, divzero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dz;
  } vec_t;

  vec_t vecs[11];

  robs_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .ovf       (ovf),
    .divzero   (divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one division, verify acceptance, exact latency and results.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    dividend = v.dvd;
    divisor  = v.dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " accept_done_low"}, {31'b0, done}, 32'd0);
    chk({tag, " accept_busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (n < 3*LAT) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    chk({tag, " latency"}, n, LAT);
    chk({tag, " quotient"}, {24'b0, quotient}, {24'b0, v.q});
    chk({tag, " remainder"}, {24'b0, remainder}, {24'b0, v.r});
    chk({tag, " ovf"}, {31'b0, ovf}, {31'b0, v.ovf});
    chk({tag, " divzero"}, {31'b0, divzero}, {31'b0, v.dz});
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    //           dividend   divisor  quot    rem    ovf   dz
    vecs[0]  = '{16'd100,   8'd7,    8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{16'hFF9C,  8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0}; // -100/7
    vecs[2]  = '{16'd100,   8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0}; // 100/-7
    vecs[3]  = '{16'h3F80,  8'h81,   8'h80, 8'h00, 1'b0, 1'b0}; // 16256/-127
    vecs[4]  = '{16'h3F80,  8'h7F,   8'h7F, 8'h00, 1'b1, 1'b0}; // 16256/127
    vecs[5]  = '{16'h03E8,  8'h00,   8'h7F, 8'h00, 1'b1, 1'b1}; // 1000/0
    vecs[6]  = '{16'hFC18,  8'h00,   8'h80, 8'h00, 1'b1, 1'b1}; // -1000/0
    vecs[7]  = '{16'h8000,  8'h80,   8'h7F, 8'h00, 1'b1, 1'b0}; // -32768/-128 = 256
    vecs[8]  = '{16'h3FFF,  8'h80,   8'h81, 8'h7F, 1'b0, 1'b0}; // 16383/-128
    vecs[9]  = '{16'h0000,  8'd5,    8'h00, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{16'd42,    8'hFB,   8'hF8, 8'h02, 1'b0, 1'b0}; // 42/-5

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset quotient", {24'b0, quotient}, 32'd0);
    chk("reset remainder", {24'b0, remainder}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset ovf", {31'b0, ovf}, 32'd0);
    chk("reset divzero", {31'b0, divzero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Result holds in DONE while start stays low.
    repeat (5) @(posedge clk);
    #1;
    chk("hold done", {31'b0, done}, 32'd1);
    chk("hold quotient", {24'b0, quotient}, 32'h0000_00F8);

    // Start pulse and operand change mid-ITER are ignored.
    begin
      int n;
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      dividend = 16'd1;
      divisor  = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 7;
      while (n < 3*LAT) begin
        @(posedge clk);
        #1;
        n++;
        if (done) break;
      end
      chk("midstart latency", n, LAT);
      chk("midstart quotient", {24'b0, quotient}, 32'h0000_000E);
      chk("midstart remainder", {24'b0, remainder}, 32'h0000_0002);
      chk("midstart ovf", {31'b0, ovf}, 32'd0);
    end

    // Reset in the middle of ITER wipes everything on the next edge.
    @(negedge clk);
    dividend = 16'hFC18;
    divisor  = 8'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset quotient", {24'b0, quotient}, 32'd0);
    chk("midreset remainder", {24'b0, remainder}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset ovf", {31'b0, ovf}, 32'd0);
    chk("midreset divzero", {31'b0, divzero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle after reset busy", {31'b0, busy}, 32'd0);
    run_vec(vecs[10], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
